// File: rtl/mgmt_bus_pkg.sv
// Shared definitions for the 8-bit management register bus: default widths,
// fill value for failed reads and the switch-level target map.
package mgmt_bus_pkg;

   localparam int MGMT_ADDR_WIDTH = 16;
   localparam int MGMT_DATA_WIDTH = 8;

   typedef logic [MGMT_ADDR_WIDTH-1:0] mgmt_addr_t;
   typedef logic [MGMT_DATA_WIDTH-1:0] mgmt_data_t;

   localparam mgmt_data_t MGMT_FILL_DEFAULT = 8'hff;

   // Window order on the switch top level; index equals the upper address bits.
   typedef enum logic [1:0] {
      TGT_SYSINFO = 2'd0,
      TGT_PORT    = 2'd1,
      TGT_CRYPT   = 2'd2,
      TGT_FIFO    = 2'd3
   } mgmt_tgt_e;

endpackage

// File: rtl/mgmt_bus_decoder.sv
// Windowed address decoder with a bounded-latency read tracker and sticky
// error flags, splitting one management bus across NUM_TARGETS register blocks.
module mgmt_bus_decoder
   import mgmt_bus_pkg::*;
#(
   parameter int NUM_TARGETS    = 4,
   parameter int ADDR_WIDTH     = 16,
   parameter int WINDOW_BITS    = 12,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 255,
   parameter logic [DATA_WIDTH-1:0] FILL_VALUE = DATA_WIDTH'(MGMT_FILL_DEFAULT)
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  rd_en,
   input  logic [ADDR_WIDTH-1:0]                 rd_addr,
   output logic                                  rd_valid,
   output logic [DATA_WIDTH-1:0]                 rd_data,
   input  logic                                  wr_en,
   input  logic [ADDR_WIDTH-1:0]                 wr_addr,
   input  logic [DATA_WIDTH-1:0]                 wr_data,
   output logic [NUM_TARGETS-1:0]                tgt_rd_en,
   output logic [WINDOW_BITS-1:0]                tgt_rd_addr,
   input  logic [NUM_TARGETS-1:0]                tgt_rd_valid,
   input  logic [NUM_TARGETS-1:0][DATA_WIDTH-1:0] tgt_rd_data,
   output logic [NUM_TARGETS-1:0]                tgt_wr_en,
   output logic [WINDOW_BITS-1:0]                tgt_wr_addr,
   output logic [DATA_WIDTH-1:0]                 tgt_wr_data,
   input  logic                                  err_clr,
   output logic                                  err_unmapped,
   output logic                                  err_timeout,
   output logic                                  err_overrun
);

   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   // An all-zero result means the index lies beyond the populated windows.
   function automatic logic [NUM_TARGETS-1:0] decode_oh(input logic [ADDR_WIDTH-1:0] addr);
      logic [NUM_TARGETS-1:0] oh;
      logic [31:0]            idx;
      idx = 32'(addr[ADDR_WIDTH-1:WINDOW_BITS]);
      for (int i = 0; i < NUM_TARGETS; i++) begin
         oh[i] = (idx == 32'(i));
      end
      return oh;
   endfunction

   logic [0:0]             state_r;
   logic [TMR_W-1:0]       timer_r;
   logic [NUM_TARGETS-1:0] sel_r;
   logic                   rd_valid_r;
   logic [DATA_WIDTH-1:0]  rd_data_r;
   logic [NUM_TARGETS-1:0] tgt_rd_en_r;
   logic [WINDOW_BITS-1:0] tgt_rd_addr_r;
   logic [NUM_TARGETS-1:0] tgt_wr_en_r;
   logic [WINDOW_BITS-1:0] tgt_wr_addr_r;
   logic [DATA_WIDTH-1:0]  tgt_wr_data_r;
   logic                   err_unmapped_r;
   logic                   err_timeout_r;
   logic                   err_overrun_r;

   logic [NUM_TARGETS-1:0] rd_oh_s;
   logic [NUM_TARGETS-1:0] wr_oh_s;
   logic                   rd_mapped_s;
   logic                   wr_mapped_s;
   logic                   rsp_hit_s;
   logic [DATA_WIDTH-1:0]  rsp_data_s;
   logic                   tmo_hit_s;
   logic                   set_unmapped_s;
   logic                   set_timeout_s;
   logic                   set_overrun_s;

   assign rd_oh_s     = decode_oh(rd_addr);
   assign wr_oh_s     = decode_oh(wr_addr);
   assign rd_mapped_s = |rd_oh_s;
   assign wr_mapped_s = |wr_oh_s;

   // Response select and error-set conditions; responses from other targets are masked out.
   always_comb begin
      rsp_hit_s  = |(tgt_rd_valid & sel_r);
      rsp_data_s = {DATA_WIDTH{1'b0}};
      for (int i = 0; i < NUM_TARGETS; i++) begin
         rsp_data_s = rsp_data_s | (sel_r[i] ? tgt_rd_data[i] : {DATA_WIDTH{1'b0}});
      end
      tmo_hit_s      = (state_r == ST_WAIT) && !rsp_hit_s && (timer_r == TMR_MAX);
      set_unmapped_s = (rd_en && (state_r == ST_IDLE) && !rd_mapped_s) || (wr_en && !wr_mapped_s);
      set_timeout_s  = tmo_hit_s;
      set_overrun_s  = rd_en && (state_r == ST_WAIT);
   end

   // Read FSM, timer, write path and sticky flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= ST_IDLE;
         timer_r        <= {TMR_W{1'b0}};
         sel_r          <= {NUM_TARGETS{1'b0}};
         rd_valid_r     <= 1'b0;
         rd_data_r      <= {DATA_WIDTH{1'b0}};
         tgt_rd_en_r    <= {NUM_TARGETS{1'b0}};
         tgt_rd_addr_r  <= {WINDOW_BITS{1'b0}};
         tgt_wr_en_r    <= {NUM_TARGETS{1'b0}};
         tgt_wr_addr_r  <= {WINDOW_BITS{1'b0}};
         tgt_wr_data_r  <= {DATA_WIDTH{1'b0}};
         err_unmapped_r <= 1'b0;
         err_timeout_r  <= 1'b0;
         err_overrun_r  <= 1'b0;
      end else begin
         rd_valid_r  <= 1'b0;
         tgt_rd_en_r <= {NUM_TARGETS{1'b0}};
         tgt_wr_en_r <= {NUM_TARGETS{1'b0}};

         case (state_r)
            ST_IDLE: begin
               if (rd_en && rd_mapped_s) begin
                  tgt_rd_en_r   <= rd_oh_s;
                  tgt_rd_addr_r <= rd_addr[WINDOW_BITS-1:0];
                  sel_r         <= rd_oh_s;
                  timer_r       <= {TMR_W{1'b0}};
                  state_r       <= ST_WAIT;
               end else if (rd_en) begin
                  rd_valid_r <= 1'b1;
                  rd_data_r  <= FILL_VALUE;
               end
            end
            ST_WAIT: begin
               if (rsp_hit_s) begin
                  rd_valid_r <= 1'b1;
                  rd_data_r  <= rsp_data_s;
                  state_r    <= ST_IDLE;
               end else if (tmo_hit_s) begin
                  rd_valid_r <= 1'b1;
                  rd_data_r  <= FILL_VALUE;
                  state_r    <= ST_IDLE;
               end else begin
                  timer_r <= timer_r + TMR_W'(1);
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase

         if (wr_en && wr_mapped_s) begin
            tgt_wr_en_r   <= wr_oh_s;
            tgt_wr_addr_r <= wr_addr[WINDOW_BITS-1:0];
            tgt_wr_data_r <= wr_data;
         end

         err_unmapped_r <= set_unmapped_s | (err_unmapped_r & ~err_clr);
         err_timeout_r  <= set_timeout_s  | (err_timeout_r  & ~err_clr);
         err_overrun_r  <= set_overrun_s  | (err_overrun_r  & ~err_clr);
      end
   end

   assign rd_valid     = rd_valid_r;
   assign rd_data      = rd_data_r;
   assign tgt_rd_en    = tgt_rd_en_r;
   assign tgt_rd_addr  = tgt_rd_addr_r;
   assign tgt_wr_en    = tgt_wr_en_r;
   assign tgt_wr_addr  = tgt_wr_addr_r;
   assign tgt_wr_data  = tgt_wr_data_r;
   assign err_unmapped = err_unmapped_r;
   assign err_timeout  = err_timeout_r;
   assign err_overrun  = err_overrun_r;

endmodule

// File: tb/tb_mgmt_bus_decoder.sv
// Directed bench for mgmt_bus_decoder: a transaction-level model predicts every
// output each cycle, and literal expectations pin the key scenarios.
module tb_mgmt_bus_decoder;

   localparam int NT  = 4;
   localparam int AW  = 16;
   localparam int WB  = 12;
   localparam int DW  = 8;
   localparam int TMO = 8;
   localparam int WIN = 4096;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  rd_en;
   logic [AW-1:0]         rd_addr;
   logic                  rd_valid;
   logic [DW-1:0]         rd_data;
   logic                  wr_en;
   logic [AW-1:0]         wr_addr;
   logic [DW-1:0]         wr_data;
   logic [NT-1:0]         tgt_rd_en;
   logic [WB-1:0]         tgt_rd_addr;
   logic [NT-1:0]         tgt_rd_valid;
   logic [NT-1:0][DW-1:0] tgt_rd_data;
   logic [NT-1:0]         tgt_wr_en;
   logic [WB-1:0]         tgt_wr_addr;
   logic [DW-1:0]         tgt_wr_data;
   logic                  err_clr;
   logic                  err_unmapped;
   logic                  err_timeout;
   logic                  err_overrun;

   int checks   = 0;
   int failures = 0;

   mgmt_bus_decoder #(
      .NUM_TARGETS(NT), .ADDR_WIDTH(AW), .WINDOW_BITS(WB), .DATA_WIDTH(DW),
      .TIMEOUT_CYCLES(TMO), .FILL_VALUE(8'hff)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .tgt_rd_en(tgt_rd_en), .tgt_rd_addr(tgt_rd_addr),
      .tgt_rd_valid(tgt_rd_valid), .tgt_rd_data(tgt_rd_data),
      .tgt_wr_en(tgt_wr_en), .tgt_wr_addr(tgt_wr_addr), .tgt_wr_data(tgt_wr_data),
      .err_clr(err_clr), .err_unmapped(err_unmapped),
      .err_timeout(err_timeout), .err_overrun(err_overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: one outstanding read tracked by target index and an absolute deadline edge.
   typedef struct packed {
      bit           busy;
      int           sel;
      int           deadline;
      int           edge_no;
      logic         rd_valid;
      logic [7:0]   rd_data;
      logic [3:0]   trd_en;
      logic [11:0]  trd_addr;
      logic [3:0]   twr_en;
      logic [11:0]  twr_addr;
      logic [7:0]   twr_data;
      logic         eu;
      logic         et;
      logic         eo;
   } model_t;

   model_t m = '0;

   function automatic model_t model_next(input model_t s);
      model_t n;
      int     ridx;
      int     widx;
      bit     was_busy;
      bit     su;
      bit     st;
      bit     so;
      n          = s;
      n.edge_no  = s.edge_no + 1;
      n.rd_valid = 1'b0;
      n.trd_en   = 4'b0000;
      n.twr_en   = 4'b0000;
      su = 1'b0; st = 1'b0; so = 1'b0;
      ridx     = int'(rd_addr) / WIN;
      widx     = int'(wr_addr) / WIN;
      was_busy = s.busy;
      if (was_busy) begin
         if (tgt_rd_valid[s.sel]) begin
            n.rd_valid = 1'b1;
            n.rd_data  = tgt_rd_data[s.sel];
            n.busy     = 1'b0;
         end else if (n.edge_no == s.deadline) begin
            n.rd_valid = 1'b1;
            n.rd_data  = 8'hff;
            n.busy     = 1'b0;
            st         = 1'b1;
         end
      end
      if (rd_en) begin
         if (was_busy) begin
            so = 1'b1;
         end else if (ridx < NT) begin
            n.trd_en   = 4'(1 << ridx);
            n.trd_addr = 12'(int'(rd_addr) % WIN);
            n.busy     = 1'b1;
            n.sel      = ridx;
            n.deadline = n.edge_no + 1 + TMO;
         end else begin
            n.rd_valid = 1'b1;
            n.rd_data  = 8'hff;
            su         = 1'b1;
         end
      end
      if (wr_en) begin
         if (widx < NT) begin
            n.twr_en   = 4'(1 << widx);
            n.twr_addr = 12'(int'(wr_addr) % WIN);
            n.twr_data = wr_data;
         end else begin
            su = 1'b1;
         end
      end
      n.eu = su ? 1'b1 : (err_clr ? 1'b0 : s.eu);
      n.et = st ? 1'b1 : (err_clr ? 1'b0 : s.et);
      n.eo = so ? 1'b1 : (err_clr ? 1'b0 : s.eo);
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= '0;
      else        m <= model_next(m);
   end

   // Per-cycle comparison of every output against the model, mid-cycle.
   always @(negedge clk) begin
      chk("rd_valid", 32'(rd_valid), 32'(m.rd_valid));
      chk("rd_data", 32'(rd_data), 32'(m.rd_data));
      chk("tgt_rd_en", 32'(tgt_rd_en), 32'(m.trd_en));
      chk("tgt_rd_addr", 32'(tgt_rd_addr), 32'(m.trd_addr));
      chk("tgt_wr_en", 32'(tgt_wr_en), 32'(m.twr_en));
      if (m.twr_en != 4'b0000) begin
         chk("tgt_wr_addr", 32'(tgt_wr_addr), 32'(m.twr_addr));
         chk("tgt_wr_data", 32'(tgt_wr_data), 32'(m.twr_data));
      end
      chk("err_unmapped", 32'(err_unmapped), 32'(m.eu));
      chk("err_timeout", 32'(err_timeout), 32'(m.et));
      chk("err_overrun", 32'(err_overrun), 32'(m.eo));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      rd_en        = 1'b0;
      wr_en        = 1'b0;
      err_clr      = 1'b0;
      tgt_rd_valid = 4'b0000;
   endtask

   initial begin
      rst_n        = 1'b0;
      rd_addr      = 16'h0000;
      wr_addr      = 16'h0000;
      wr_data      = 8'h00;
      tgt_rd_data  = {8'hd3, 8'hc2, 8'hb1, 8'he0};
      quiet();
      repeat (3) tick();
      chk("reset_rd_valid", 32'(rd_valid), 32'd0);
      chk("reset_tgt_rd_en", 32'(tgt_rd_en), 32'd0);
      chk("reset_errs", 32'({err_unmapped, err_timeout, err_overrun}), 32'd0);
      rst_n = 1'b1;
      tick();

      // Mapped read, target 1 answers three cycles after the strobe.
      rd_en = 1'b1; rd_addr = 16'h1234;
      tick(); quiet();
      chk("rd1234_strobe", 32'(tgt_rd_en), 32'b0010);
      chk("rd1234_addr", 32'(tgt_rd_addr), 32'h234);
      tick(); tick(); tick();
      tgt_rd_valid = 4'b0010; tgt_rd_data[1] = 8'ha5;
      tick(); quiet();
      chk("rd1234_valid", 32'(rd_valid), 32'd1);
      chk("rd1234_data", 32'(rd_data), 32'ha5);
      chk("rd1234_errs", 32'({err_unmapped, err_timeout, err_overrun}), 32'd0);
      tick();
      chk("rd1234_hold", 32'({rd_valid, rd_data}), 32'h0a5);

      // Unmapped read, then clear the flag.
      rd_en = 1'b1; rd_addr = 16'h5000;
      tick(); quiet();
      chk("rd5000_valid", 32'({rd_valid, rd_data}), 32'h1ff);
      chk("rd5000_err", 32'(err_unmapped), 32'd1);
      chk("rd5000_nostrobe", 32'(tgt_rd_en), 32'd0);
      err_clr = 1'b1;
      tick(); quiet();
      chk("clr_unmapped", 32'(err_unmapped), 32'd0);

      // Timeout on a silent target 0, then a late response.
      rd_en = 1'b1; rd_addr = 16'h0010;
      tick(); quiet();
      repeat (8) tick();
      chk("tmo_not_yet", 32'(rd_valid), 32'd0);
      tick();
      chk("tmo_valid", 32'({rd_valid, rd_data}), 32'h1ff);
      chk("tmo_err", 32'(err_timeout), 32'd1);
      tgt_rd_valid = 4'b0001; tgt_rd_data[0] = 8'h33;
      tick(); quiet();
      chk("tmo_late_ignored", 32'({rd_valid, rd_data}), 32'h0ff);
      err_clr = 1'b1;
      tick(); quiet();

      // Response arrives on the deadline cycle: data wins, no timeout.
      rd_en = 1'b1; rd_addr = 16'h3040;
      tick(); quiet();
      repeat (8) tick();
      tgt_rd_valid = 4'b1000; tgt_rd_data[3] = 8'h42;
      tick(); quiet();
      chk("tie_valid", 32'({rd_valid, rd_data}), 32'h142);
      chk("tie_no_tmo", 32'(err_timeout), 32'd0);

      // Overrun plus a stray response from a non-selected target.
      rd_en = 1'b1; rd_addr = 16'h0020;
      tick(); quiet();
      rd_en = 1'b1; rd_addr = 16'h1000;
      tgt_rd_valid = 4'b0100; tgt_rd_data[2] = 8'h77;
      tick(); quiet();
      chk("ovr_err", 32'(err_overrun), 32'd1);
      chk("ovr_no_valid", 32'(rd_valid), 32'd0);
      chk("ovr_no_strobe", 32'(tgt_rd_en), 32'd0);
      tgt_rd_valid = 4'b0001; tgt_rd_data[0] = 8'h3c;
      tick(); quiet();
      chk("ovr_complete", 32'({rd_valid, rd_data}), 32'h13c);

      // Simultaneous write and read.
      wr_en = 1'b1; wr_addr = 16'h3001; wr_data = 8'h5a;
      rd_en = 1'b1; rd_addr = 16'h2002;
      tick(); quiet();
      chk("wr_strobe", 32'(tgt_wr_en), 32'b1000);
      chk("wr_addr", 32'(tgt_wr_addr), 32'h001);
      chk("wr_data", 32'(tgt_wr_data), 32'h5a);
      chk("wr_rd_strobe", 32'({tgt_rd_en, tgt_rd_addr}), 32'h4002);
      tgt_rd_valid = 4'b0100; tgt_rd_data[2] = 8'h11;
      tick(); quiet();
      chk("wr_rd_done", 32'({rd_valid, rd_data}), 32'h111);

      // Unmapped write with err_clr in the same cycle: set wins.
      wr_en = 1'b1; wr_addr = 16'h8000; wr_data = 8'h99; err_clr = 1'b1;
      tick(); quiet();
      chk("wr_unmapped_err", 32'(err_unmapped), 32'd1);
      chk("wr_unmapped_nostrobe", 32'(tgt_wr_en), 32'd0);
      chk("clr_overrun", 32'(err_overrun), 32'd0);

      // Reset in the middle of a read.
      rd_en = 1'b1; rd_addr = 16'h1100;
      tick(); quiet();
      tick();
      rst_n = 1'b0;
      #1;
      chk("rst_mid_outputs", 32'({rd_valid, rd_data, tgt_rd_en, tgt_wr_en}), 32'd0);
      chk("rst_mid_errs", 32'({err_unmapped, err_timeout, err_overrun}), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      tgt_rd_valid = 4'b0010; tgt_rd_data[1] = 8'h66;
      tick(); quiet();
      chk("rst_late_ignored", 32'(rd_valid), 32'd0);
      rd_en = 1'b1; rd_addr = 16'h2345;
      tick(); quiet();
      chk("post_rst_strobe", 32'({tgt_rd_en, tgt_rd_addr}), 32'h4345);
      tgt_rd_valid = 4'b0100; tgt_rd_data[2] = 8'h99;
      tick(); quiet();
      chk("post_rst_done", 32'({rd_valid, rd_data}), 32'h199);
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
